// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_stream_reader
// Purpose  : Walks a contiguous RAM address range on command, issues reads to
//            a synchronous-read port and streams the returned words out on a
//            valid/ready interface with full backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  inflight_last;

  // Two-entry output buffer: head drives the stream outputs directly.
  logic                  head_valid;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  tail_valid;
  logic                  tail_last;
  logic [DATA_WIDTH-1:0] tail_data;

  logic       accept;
  logic       issue;
  logic [1:0] held_after;

  assign accept    = head_valid & out_ready;
  assign mem_rd_en = issue;
  assign mem_addr  = addr;
  assign busy      = (state != IDLE);
  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_last  = head_last;

  // A read may only be issued if the word it returns is guaranteed a slot:
  // buffered words plus the in-flight read, after this cycle's accept, must be < 2.
  always_comb begin
    held_after = {1'b0, head_valid} + {1'b0, tail_valid} + {1'b0, inflight}
               - {1'b0, accept};
    issue      = (state == READ) && (remaining != '0) && (held_after < 2'd2);
  end

  // Command sequencing: capture, address walk, drain, and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              addr      <= base_addr;
              remaining <= count;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (accept && head_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the read whose data arrives on mem_rdata this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == CNT_ONE);
    end
  end

  // Output buffer: pop from head on accept, push returning read data behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      head_data  <= '0;
      tail_valid <= 1'b0;
      tail_last  <= 1'b0;
      tail_data  <= '0;
    end else if (accept) begin
      if (tail_valid) begin
        head_data  <= tail_data;
        head_last  <= tail_last;
        tail_valid <= inflight;
        if (inflight) begin
          tail_data <= mem_rdata;
          tail_last <= inflight_last;
        end
      end else if (inflight) begin
        head_data <= mem_rdata;
        head_last <= inflight_last;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (inflight) begin
      if (!head_valid) begin
        head_valid <= 1'b1;
        head_data  <= mem_rdata;
        head_last  <= inflight_last;
      end else begin
        tail_valid <= 1'b1;
        tail_data  <= mem_rdata;
        tail_last  <= inflight_last;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_stream_reader
// Purpose  : Self-checking bench for ram_stream_reader with a RAM model,
//            expected-address and expected-word scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, mem_rd_en, out_valid, out_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;

  logic [DW-1:0] ram [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int outstanding = 0;
  int acc_count = 0;
  int done_count = 0;
  int last_acc_cyc = 0;
  int done_cyc = 0;
  int ready_mode = 0;

  logic [DW:0]   exp_words[$];
  logic [AW-1:0] exp_addrs[$];

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  // Consumer ready: always high, or the repeating 1,0,0,1,0,1 pattern
  initial begin
    logic [5:0] pat;
    int k;
    pat = 6'b101001;
    k = 0;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) begin
        out_ready = pat[k];
        k = (k + 1) % 6;
      end else begin
        out_ready = 1'b1;
        k = 0;
      end
    end
  end

  // Scoreboard monitor sampled on the falling edge
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            acc;
    logic [AW-1:0] ea;
    logic [DW:0]   ew;
    prev_stall = 0; prev_data = '0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        outstanding = 0;
        prev_stall = 0;
      end else begin
        acc = (out_valid && out_ready) ? 1 : 0;
        if (prev_stall) begin
          vectors++;
          if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
            miscompares++;
            $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, need valid=1 data=%h last=%0b",
                     out_valid, out_data, out_last, prev_data, prev_last);
          end
        end
        if (mem_rd_en) begin
          vectors++;
          if (outstanding - acc >= 2) begin
            miscompares++;
            $display("FAIL rd_when_full: got read with %0d held, need < 2", outstanding - acc);
          end
          vectors++;
          if (exp_addrs.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_read: got addr %h, need no read", mem_addr);
          end else begin
            ea = exp_addrs.pop_front();
            if (mem_addr !== ea) begin
              miscompares++;
              $display("FAIL read_addr: got %h, need %h", mem_addr, ea);
            end
          end
        end
        if (acc == 1) begin
          vectors++;
          if (exp_words.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got data=%h last=%0b, need none", out_data, out_last);
          end else begin
            ew = exp_words.pop_front();
            if ({out_last, out_data} !== ew) begin
              miscompares++;
              $display("FAIL word: got last=%0b data=%h, need last=%0b data=%h",
                       out_last, out_data, ew[DW], ew[DW-1:0]);
            end
          end
          acc_count++;
          last_acc_cyc = cyc;
        end
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
        outstanding = outstanding + (mem_rd_en ? 1 : 0) - acc;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Drive one start strobe; optionally load the expected reads and words
  task automatic issue(input logic [AW-1:0] b, input logic [AW:0] c,
                       input bit expect_it, output int t);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = c;
    t = cyc;
    if (expect_it) begin
      for (int i = 0; i < int'(c); i++) begin
        a = b + AW'(i);
        exp_addrs.push_back(a);
        exp_words.push_back({(i == int'(c) - 1), ram[a]});
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    for (int i = 0; i < limit && done_count == d0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy/done/rd/valid/last=%b, need 00000",
               {busy, done, mem_rd_en, out_valid, out_last});
    end
    vectors++;
    if (mem_addr !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got addr=%h data=%h, need 0 0", mem_addr, out_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int t, fv, d0;
    ram[100] = 16'h1111; ram[101] = 16'h2222; ram[102] = 16'h3333; ram[103] = 16'h4444;
    d0 = done_count;
    fv = -1;
    issue(14'd100, 15'd4, 1, t);
    for (int i = 0; i < 12 && fv < 0; i++) begin
      if (out_valid) fv = cyc;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (fv - t !== 3) begin
      miscompares++;
      $display("FAIL first_valid_latency: got %0d, need 3", fv - t);
    end
    wait_done(d0, 30);
    vectors++;
    if (last_acc_cyc - fv !== 3) begin
      miscompares++;
      $display("FAIL throughput: got last accept %0d cycles after first valid, need 3", last_acc_cyc - fv);
    end
    vectors++;
    if (done_count - d0 !== 1 || done_cyc !== last_acc_cyc + 1) begin
      miscompares++;
      $display("FAIL basic_done: got %0d pulses at %0d, need 1 at %0d", done_count - d0, done_cyc, last_acc_cyc + 1);
    end
    vectors++;
    if (busy !== 1'b0 || exp_words.size() != 0) begin
      miscompares++;
      $display("FAIL basic_end: got busy=%0b pending=%0d, need 0 0", busy, exp_words.size());
    end
  endtask

  task automatic test_backpressure;
    int t, d0;
    d0 = done_count;
    ready_mode = 1;
    issue(14'd100, 15'd4, 1, t);
    wait_done(d0, 60);
    ready_mode = 0;
    vectors++;
    if (done_count - d0 !== 1 || done_cyc !== last_acc_cyc + 1) begin
      miscompares++;
      $display("FAIL bp_done: got %0d pulses at %0d, need 1 at %0d", done_count - d0, done_cyc, last_acc_cyc + 1);
    end
    vectors++;
    if (exp_words.size() != 0) begin
      miscompares++;
      $display("FAIL bp_pending: got %0d words left, need 0", exp_words.size());
    end
  endtask

  task automatic test_wrap;
    int t, d0;
    d0 = done_count;
    issue(14'h3FFE, 15'd4, 1, t);
    wait_done(d0, 30);
    vectors++;
    if (done_count - d0 !== 1 || exp_words.size() != 0 || exp_addrs.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_end: got %0d pulses, %0d words left, need 1 pulse 0 left", done_count - d0, exp_words.size());
    end
  endtask

  task automatic test_zero_and_busy;
    int t, d0;
    d0 = done_count;
    issue(14'd7, 15'd0, 0, t);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_count: got done=%0b busy=%0b, need done=1 busy=0", done, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (done_count - d0 !== 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after: got pulses=%0d busy=%0b valid=%0b, need 1 0 0", done_count - d0, busy, out_valid);
    end
    d0 = done_count;
    issue(14'd200, 15'd8, 1, t);
    repeat (2) @(posedge clk);
    issue(14'd3000, 15'd5, 0, t);
    wait_done(d0, 40);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done_count - d0 !== 1 || exp_words.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start: got pulses=%0d left=%0d busy=%0b, need 1 0 0", done_count - d0, exp_words.size(), busy);
    end
  endtask

  task automatic test_reset_mid;
    int t, a0, d0;
    d0 = done_count;
    a0 = acc_count;
    issue(14'd50, 15'd10, 1, t);
    for (int i = 0; i < 40 && acc_count - a0 < 3; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_words.delete();
    exp_addrs.delete();
    vectors++;
    if ({out_valid, busy, mem_rd_en, done} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid/busy/rd/done=%b, need 0000", {out_valid, busy, mem_rd_en, done});
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done_count !== d0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d pulses, need 0", done_count - d0);
    end
    issue(14'd0, 15'd2, 1, t);
    wait_done(d0, 30);
    vectors++;
    if (done_count - d0 !== 1 || exp_words.size() != 0) begin
      miscompares++;
      $display("FAIL after_reset: got pulses=%0d left=%0d, need 1 0", done_count - d0, exp_words.size());
    end
  endtask

  task automatic test_full_ram;
    int t, a0, d0;
    d0 = done_count;
    a0 = acc_count;
    issue(14'd5, 15'd16384, 1, t);
    wait_done(d0, 17000);
    vectors++;
    if (acc_count - a0 !== 16384 || done_count - d0 !== 1) begin
      miscompares++;
      $display("FAIL full_ram: got words=%0d pulses=%0d, need 16384 1", acc_count - a0, done_count - d0);
    end
    vectors++;
    if (exp_addrs.size() != 0 || exp_words.size() != 0) begin
      miscompares++;
      $display("FAIL full_ram_left: got %0d reads %0d words left, need 0 0", exp_addrs.size(), exp_words.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 40503 + 4660);
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero_and_busy;
    test_reset_mid;
    test_full_ram;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
